// File: rtl/spi2wb_if.sv
// Wishbone classic byte-wide bus between the SPI target bridge (master)
// and an on-chip slave such as the pattern memory.
interface spi2wb_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [22:0] adr_o;
    logic [7:0]  dat_o;
    logic [7:0]  dat_i;
    logic        ack_i;
    logic        err_i;

    modport master (output cyc_o, stb_o, we_o, adr_o, dat_o,
                    input  dat_i, ack_i, err_i);
    modport slave  (input  cyc_o, stb_o, we_o, adr_o, dat_o,
                    output dat_i, ack_i, err_i);
endinterface

// File: rtl/spi2wb.sv
// SPI mode-0 target that turns SRAM-style 0x02 WRITE / 0x03 READ commands
// into Wishbone classic byte cycles, with auto-incrementing bursts.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ss_n high, waiting for select
// CMD     | shifting in the command byte
// ADDR    | shifting in 24 address bits (bit 23 dropped)
// WR_DATA | each completed byte becomes one Wishbone write
// RD_DATA | prefetched Wishbone reads are shifted out on miso
// IGNORE  | unknown command, miso held low, no bus traffic
module spi2wb (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     sck,
    input  logic     mosi,
    input  logic     ss_n,
    output logic     miso,
    output logic     miso_oe,
    output logic     underrun,
    spi2wb_if.master wb
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ADDR    = 3'd2,
        WR_DATA = 3'd3,
        RD_DATA = 3'd4,
        IGNORE  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [2:0]  r_sck_s;
    logic [1:0]  r_mosi_s;
    logic [1:0]  r_ss_s;
    logic [4:0]  r_cnt;
    logic [6:0]  r_rx;
    logic        r_cmd_rd;
    logic [22:0] r_adr;
    logic        r_wr_pend;
    logic        r_rd_pend;
    logic [7:0]  r_wdat;
    logic [7:0]  r_rbuf;
    logic        r_rbuf_vld;
    logic        r_pf_arm;
    logic [7:0]  r_tx;
    logic [2:0]  r_tx_cnt;
    logic        r_cyc;
    logic        r_we;
    logic        r_drain;
    logic [22:0] r_wb_adr;
    logic [7:0]  r_wb_dat;
    logic        r_miso;
    logic        r_miso_oe;
    logic        r_underrun;

    logic        w_rise;
    logic        w_fall;
    logic        w_mosi;
    logic        w_ss_n;
    logic [7:0]  w_byte;
    logic        w_byte_done;
    logic        w_term;
    logic        w_issue_wr;
    logic        w_issue_rd;

    assign w_rise      = r_sck_s[1] & ~r_sck_s[2];
    assign w_fall      = ~r_sck_s[1] & r_sck_s[2];
    assign w_mosi      = r_mosi_s[1];
    assign w_ss_n      = r_ss_s[1];
    assign w_byte      = {r_rx, w_mosi};
    assign w_byte_done = w_rise && (r_cnt == 5'd0);
    assign w_term      = r_cyc && (wb.ack_i || wb.err_i);
    assign w_issue_wr  = r_wr_pend && !r_cyc && !w_ss_n;
    assign w_issue_rd  = r_rd_pend && !r_cyc && !w_ss_n;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_ss_n) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = CMD;
                CMD:     if (w_byte_done)
                             w_state_nxt = (w_byte == 8'h02 || w_byte == 8'h03) ? ADDR : IGNORE;
                ADDR:    if (w_byte_done)
                             w_state_nxt = r_cmd_rd ? RD_DATA : WR_DATA;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sck_s    <= 3'b000;
            r_mosi_s   <= 2'b00;
            r_ss_s     <= 2'b11;
            r_cnt      <= 5'd7;
            r_rx       <= 7'd0;
            r_cmd_rd   <= 1'b0;
            r_adr      <= 23'd0;
            r_wr_pend  <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_wdat     <= 8'd0;
            r_rbuf     <= 8'd0;
            r_rbuf_vld <= 1'b0;
            r_pf_arm   <= 1'b0;
            r_tx       <= 8'd0;
            r_tx_cnt   <= 3'd0;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_drain    <= 1'b0;
            r_wb_adr   <= 23'd0;
            r_wb_dat   <= 8'd0;
            r_miso     <= 1'b0;
            r_miso_oe  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_sck_s    <= {r_sck_s[1:0], sck};
            r_mosi_s   <= {r_mosi_s[0], mosi};
            r_ss_s     <= {r_ss_s[0], ss_n};
            r_miso_oe  <= ~w_ss_n;
            r_underrun <= 1'b0;

            if (w_rise) r_rx <= w_byte[6:0];

            if (r_state == IDLE) begin
                r_cnt <= 5'd7;
            end else if (w_rise) begin
                if (r_cnt != 5'd0)     r_cnt <= r_cnt - 5'd1;
                else if (r_state == CMD) r_cnt <= 5'd23;
                else                   r_cnt <= 5'd7;
            end

            if (r_state == CMD && w_byte_done) r_cmd_rd <= w_byte[0];

            if (r_state == ADDR && w_rise) begin
                r_adr <= {r_adr[21:0], w_mosi};
                if (w_byte_done && r_cmd_rd) r_rd_pend <= 1'b1;
            end

            if (r_state == WR_DATA && w_byte_done) begin
                if (r_wr_pend || (r_cyc && !r_drain)) begin
                    r_underrun <= 1'b1;
                end else begin
                    r_wr_pend <= 1'b1;
                    r_wdat    <= w_byte;
                end
            end

            if (w_issue_wr) begin
                r_cyc     <= 1'b1;
                r_we      <= 1'b1;
                r_wb_adr  <= r_adr;
                r_wb_dat  <= r_wdat;
                r_adr     <= r_adr + 23'd1;
                r_wr_pend <= 1'b0;
            end else if (w_issue_rd) begin
                r_cyc     <= 1'b1;
                r_we      <= 1'b0;
                r_wb_adr  <= r_adr;
                r_adr     <= r_adr + 23'd1;
                r_rd_pend <= 1'b0;
            end

            // Next byte is fetched on the first rise of the current byte, leaving most of a byte time of slack.
            if (r_state != RD_DATA) begin
                r_miso   <= 1'b0;
                r_tx     <= 8'd0;
                r_tx_cnt <= 3'd0;
                r_pf_arm <= 1'b0;
            end else begin
                if (w_rise && r_pf_arm) begin
                    r_rd_pend <= 1'b1;
                    r_pf_arm  <= 1'b0;
                end
                if (w_fall) begin
                    if (r_tx_cnt == 3'd0) begin
                        r_tx_cnt <= 3'd7;
                        if (r_rbuf_vld) begin
                            r_miso     <= r_rbuf[7];
                            r_tx       <= {r_rbuf[6:0], 1'b0};
                            r_rbuf_vld <= 1'b0;
                            r_pf_arm   <= 1'b1;
                        end else begin
                            r_miso     <= 1'b0;
                            r_tx       <= 8'd0;
                            r_underrun <= 1'b1;
                        end
                    end else begin
                        r_miso   <= r_tx[7];
                        r_tx     <= {r_tx[6:0], 1'b0};
                        r_tx_cnt <= r_tx_cnt - 3'd1;
                    end
                end
            end

            if (w_term) begin
                r_cyc   <= 1'b0;
                r_we    <= 1'b0;
                r_drain <= 1'b0;
                if (!r_we && !r_drain && !w_ss_n) begin
                    r_rbuf     <= wb.err_i ? 8'h00 : wb.dat_i;
                    r_rbuf_vld <= 1'b1;
                end
            end

            // Deselect drops queued work; a cycle already on the bus is left to drain.
            if (w_ss_n) begin
                r_wr_pend  <= 1'b0;
                r_rd_pend  <= 1'b0;
                r_rbuf_vld <= 1'b0;
                if (r_cyc && !w_term) r_drain <= 1'b1;
            end
        end
    end

    assign wb.cyc_o = r_cyc;
    assign wb.stb_o = r_cyc;
    assign wb.we_o  = r_we;
    assign wb.adr_o = r_wb_adr;
    assign wb.dat_o = r_wb_dat;
    assign miso     = r_miso;
    assign miso_oe  = r_miso_oe;
    assign underrun = r_underrun;
endmodule

// File: tb/tb_spi2wb.sv
// Bench for spi2wb: bit-banged SPI host, Wishbone slave model and
// scoreboards for expected bus cycles and miso bytes.
module tb_spi2wb;
    localparam int HALF = 10;

    typedef struct packed {
        logic        we;
        logic [22:0] adr;
        logic [7:0]  dat;
        logic [7:0]  dly;
    } bus_t;

    logic clk_i = 1'b0;
    logic rst_i;
    logic sck;
    logic mosi;
    logic ss_n;
    logic miso;
    logic miso_oe;
    logic underrun;

    spi2wb_if wb();

    spi2wb dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sck      (sck),
        .mosi     (mosi),
        .ss_n     (ss_n),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .underrun (underrun),
        .wb       (wb)
    );

    always #5 clk_i = ~clk_i;

    int         n_chk = 0;
    int         n_fail = 0;
    int         ur_cnt = 0;
    bus_t       bus_q[$];
    logic [7:0] miso_q[$];
    logic [7:0] mem [0:255];
    logic [7:0] tx_buf [0:7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bus_t mk(input logic we, input logic [22:0] adr,
                                input logic [7:0] dat, input logic [7:0] dly);
        bus_t b;
        b.we  = we;
        b.adr = adr;
        b.dat = dat;
        b.dly = dly;
        return b;
    endfunction

    // Wishbone slave: each new cycle is checked against the head of bus_q.
    initial begin
        bus_t       e;
        logic [7:0] cnt;
        bit         busy;
        busy = 0;
        cnt  = 8'd1;
        wb.ack_i = 1'b0;
        wb.err_i = 1'b0;
        wb.dat_i = 8'h00;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                busy = 0;
                wb.ack_i = 1'b0;
            end else if (wb.ack_i) begin
                wb.ack_i = 1'b0;
            end else begin
                if (wb.cyc_o && !busy) begin
                    busy = 1;
                    cnt  = 8'd1;
                    check("bus_expected", 32'(bus_q.size() > 0), 1);
                    check("bus_stb", wb.stb_o, 1);
                    if (bus_q.size() > 0) begin
                        e = bus_q.pop_front();
                        check("bus_we", wb.we_o, e.we);
                        check("bus_adr", wb.adr_o, e.adr);
                        if (e.we) check("bus_dat", wb.dat_o, e.dat);
                        cnt = e.dly;
                    end
                end
                if (busy) begin
                    if (cnt <= 8'd1) begin
                        wb.ack_i = 1'b1;
                        wb.dat_i = mem[wb.adr_o[7:0]];
                        busy = 0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (underrun === 1'b1) ur_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk_i);
            rx[i] = miso;
            sck = 1'b1;
            repeat (HALF) @(negedge clk_i);
            sck = 1'b0;
        end
    endtask

    task automatic spi_begin();
        ss_n = 1'b0;
        repeat (HALF) @(negedge clk_i);
        check("miso_oe_sel", miso_oe, 1);
    endtask

    task automatic spi_end();
        repeat (HALF) @(negedge clk_i);
        ss_n = 1'b1;
        repeat (3 * HALF) @(negedge clk_i);
        check("miso_oe_desel", miso_oe, 0);
    endtask

    // Bytes in [lo, hi) are compared against miso_q.
    task automatic spi_txn(input int n, input int lo, input int hi);
        logic [7:0] rx;
        spi_begin();
        for (int i = 0; i < n; i++) begin
            spi_bits(tx_buf[i], 8, rx);
            if (i >= lo && i < hi) begin
                check("miso_expected", 32'(miso_q.size() > 0), 1);
                if (miso_q.size() > 0) check("miso_byte", rx, miso_q.pop_front());
            end
        end
        spi_end();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && (bus_q.size() != 0 || wb.cyc_o); i++) @(negedge clk_i);
        check(tag, bus_q.size(), 0);
    endtask

    initial begin
        int         ur0;
        logic [7:0] rx;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[8'h23] = 8'h5A;
        mem[8'h10] = 8'hC1;
        mem[8'h11] = 8'hC2;
        mem[8'h12] = 8'hC3;
        mem[8'h13] = 8'hC4;
        mem[8'h30] = 8'h99;

        rst_i = 1'b1;
        sck   = 1'b0;
        mosi  = 1'b0;
        ss_n  = 1'b1;
        repeat (5) @(negedge clk_i);
        check("rst_cyc", wb.cyc_o, 0);
        check("rst_stb", wb.stb_o, 0);
        check("rst_we", wb.we_o, 0);
        check("rst_adr", wb.adr_o, 0);
        check("rst_dat", wb.dat_o, 0);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_underrun", underrun, 0);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);

        // single write
        ur0 = ur_cnt;
        bus_q.push_back(mk(1'b1, 23'h000123, 8'hA5, 8'd1));
        tx_buf = '{8'h02, 8'h00, 8'h01, 8'h23, 8'hA5, 8'h00, 8'h00, 8'h00};
        spi_txn(5, 0, 0);
        drain("wr1_drain");
        check("wr1_underrun", ur_cnt - ur0, 0);

        // single read, ack after 2 clocks, plus the prefetch of the next address
        ur0 = ur_cnt;
        bus_q.push_back(mk(1'b0, 23'h000123, 8'h00, 8'd2));
        bus_q.push_back(mk(1'b0, 23'h000124, 8'h00, 8'd2));
        miso_q.push_back(8'h5A);
        tx_buf = '{8'h03, 8'h00, 8'h01, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00};
        spi_txn(5, 4, 5);
        drain("rd1_drain");
        check("rd1_underrun", ur_cnt - ur0, 0);

        // burst write across the address wrap
        ur0 = ur_cnt;
        bus_q.push_back(mk(1'b1, 23'h7FFFFF, 8'h11, 8'd1));
        bus_q.push_back(mk(1'b1, 23'h000000, 8'h22, 8'd3));
        tx_buf = '{8'h02, 8'h7F, 8'hFF, 8'hFF, 8'h11, 8'h22, 8'h00, 8'h00};
        spi_txn(6, 0, 0);
        drain("wrb_drain");
        check("wrb_underrun", ur_cnt - ur0, 0);

        // burst read of three bytes
        ur0 = ur_cnt;
        for (int a = 16; a < 20; a++) bus_q.push_back(mk(1'b0, 23'(a), 8'h00, 8'd2));
        miso_q.push_back(8'hC1);
        miso_q.push_back(8'hC2);
        miso_q.push_back(8'hC3);
        tx_buf = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        spi_txn(7, 4, 7);
        drain("rdb_drain");
        check("rdb_underrun", ur_cnt - ur0, 0);

        // unknown command: miso stays low, no bus cycles; then a normal write
        ur0 = ur_cnt;
        for (int i = 0; i < 5; i++) miso_q.push_back(8'h00);
        tx_buf = '{8'h9F, 8'hA5, 8'h5A, 8'hFF, 8'h81, 8'h00, 8'h00, 8'h00};
        spi_txn(5, 0, 5);
        drain("ign_drain");
        bus_q.push_back(mk(1'b1, 23'h000000, 8'h77, 8'd1));
        tx_buf = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h77, 8'h00, 8'h00, 8'h00};
        spi_txn(5, 0, 0);
        drain("ign_wr_drain");
        check("ign_underrun", ur_cnt - ur0, 0);

        // deselect after 4 data bits: nothing reaches the bus
        ur0 = ur_cnt;
        spi_begin();
        spi_bits(8'h02, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h60, 8, rx);
        spi_bits(8'hF0, 4, rx);
        spi_end();
        drain("part_drain");
        check("part_underrun", ur_cnt - ur0, 0);

        // reset while a read is outstanding, then a normal write
        bus_q.push_back(mk(1'b0, 23'h000040, 8'h00, 8'd40));
        spi_begin();
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h40, 8, rx);
        for (int i = 0; i < 50 && !wb.cyc_o; i++) @(negedge clk_i);
        check("rst_rd_issued", wb.cyc_o, 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_mid_cyc", wb.cyc_o, 0);
        check("rst_mid_oe", miso_oe, 0);
        rst_i = 1'b0;
        ss_n  = 1'b1;
        repeat (3 * HALF) @(negedge clk_i);
        ur0 = ur_cnt;
        bus_q.push_back(mk(1'b1, 23'h000050, 8'h3C, 8'd1));
        tx_buf = '{8'h02, 8'h00, 8'h00, 8'h50, 8'h3C, 8'h00, 8'h00, 8'h00};
        spi_txn(5, 0, 0);
        drain("rst_wr_drain");
        check("rst_wr_underrun", ur_cnt - ur0, 0);

        // slow first read: first byte goes out as 0x00 with an underrun pulse
        ur0 = ur_cnt;
        bus_q.push_back(mk(1'b0, 23'h000030, 8'h00, 8'd12));
        bus_q.push_back(mk(1'b0, 23'h000031, 8'h00, 8'd1));
        miso_q.push_back(8'h00);
        tx_buf = '{8'h03, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00};
        spi_txn(6, 4, 5);
        drain("slow_drain");
        check("slow_underrun", ur_cnt - ur0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
